data_sram_responder: RTL and testbench

- Slave end of the core's data SRAM interface; answers the core's data_sram_* requests.
- Provides an on-chip single-port data RAM with byte-strobe writes and 1-cycle read latency.
- Includes a small MMIO register page: free-running counter, LED register, scratch register, access-error status.
- Sits beside cpu_core in the SoC top.

---
 rtl/data_sram_responder.sv | 136 +++++++++++++
 tb/tb_data_sram_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Slave end of the core's data SRAM port: byte-strobed single-port RAM with a
// one-cycle read latency, plus a small MMIO page (counter, LED, scratch, error).
module data_sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        err
);
    localparam logic [15:0] OFF_COUNT    = 16'h0000;
    localparam logic [15:0] OFF_LED      = 16'h0004;
    localparam logic [15:0] OFF_SCRATCH  = 16'h0008;
    localparam logic [15:0] OFF_ERR      = 16'h000C;
    localparam logic [15:0] OFF_ERR_ADDR = 16'h0010;

    logic              w_access;
    logic              w_write;
    logic              w_mmio;
    logic              w_misalign;
    logic              w_bad;
    logic              w_good;
    logic              w_ram_we;
    logic              w_mmio_we;
    logic [3:0]        w_mask;
    logic [31:0]       w_bmask;
    logic [ADDR_W-1:0] w_idx;
    logic [15:0]       w_off;
    logic [31:0]       w_mmio_rd;

    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_rdata;
    logic [31:0]       r_count;
    logic [31:0]       r_scratch;
    logic [31:0]       r_err_addr;
    logic [15:0]       r_led;
    logic              r_err_flag;

    assign w_access = data_sram_en & data_sram_req;
    assign w_mask   = data_sram_we & data_sram_wstrb;
    assign w_write  = |w_mask;
    assign w_mmio   = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_idx    = data_sram_addr[ADDR_W+1:2];
    assign w_off    = data_sram_addr[15:0];
    assign w_bmask  = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};

    always_comb begin
        w_misalign = 1'b0;
        case (data_sram_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = data_sram_addr[0];
            2'd2:    w_misalign = |data_sram_addr[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    // A bad access touches no state other than the error capture and rdata.
    assign w_bad     = w_access & w_misalign;
    assign w_good    = w_access & ~w_misalign;
    assign w_ram_we  = w_good & w_write & ~w_mmio & resetn;
    assign w_mmio_we = w_good & w_write & w_mmio;

    always_comb begin
        w_mmio_rd = 32'h0;
        case (w_off)
            OFF_COUNT:    w_mmio_rd = r_count;
            OFF_LED:      w_mmio_rd = {16'h0, r_led};
            OFF_SCRATCH:  w_mmio_rd = r_scratch;
            OFF_ERR:      w_mmio_rd = {31'h0, r_err_flag};
            OFF_ERR_ADDR: w_mmio_rd = r_err_addr;
            default:      w_mmio_rd = 32'h0;
        endcase
    end

    // RAM array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata    <= 32'h0;
            r_count    <= 32'h0;
            r_led      <= 16'h0;
            r_scratch  <= 32'h0;
            r_err_flag <= 1'b0;
            r_err_addr <= 32'h0;
        end else begin
            r_count <= r_count + 32'd1;
            if (w_bad) begin
                r_rdata    <= 32'h0;
                r_err_flag <= 1'b1;
                if (!r_err_flag) begin
                    r_err_addr <= data_sram_addr;
                end
            end else if (w_good && !w_write) begin
                r_rdata <= w_mmio ? w_mmio_rd : r_mem[w_idx];
            end
            // w_bad and w_mmio_we never coincide, so a bad access always beats a clear.
            if (w_mmio_we) begin
                case (w_off)
                    OFF_LED: r_led <= (r_led & ~w_bmask[15:0]) |
                                      (data_sram_wdata[15:0] & w_bmask[15:0]);
                    OFF_SCRATCH: r_scratch <= (r_scratch & ~w_bmask) |
                                              (data_sram_wdata & w_bmask);
                    OFF_ERR: begin
                        if (w_mask[0] && data_sram_wdata[0]) begin
                            r_err_flag <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign led             = r_led;
    assign err             = r_err_flag;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed cases with literal expectations plus a
// randomized phase, all checked against a behavioural model every cycle.
module tb_data_sram_responder;
    localparam logic [31:0] MB = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        en;
    logic [3:0]  we;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic        err;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;
    bit preload_req = 1'b0;

    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_req   (req),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_wstrb (wstrb),
        .data_sram_size  (size),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .err             (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [0:16383];
    logic [31:0] m_rdata;
    logic [31:0] m_count;
    logic [31:0] m_scratch;
    logic [31:0] m_eaddr;
    logic [15:0] m_led;
    logic        m_err;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin : p_model
        logic [31:0] cnow;
        logic [31:0] tmp;
        logic [3:0]  m;
        logic        isbad;
        logic [15:0] off;
        int          key;
        if (!resetn) begin
            m_rdata   <= 32'h0;
            m_count   <= 32'h0;
            m_led     <= 16'h0;
            m_scratch <= 32'h0;
            m_err     <= 1'b0;
            m_eaddr   <= 32'h0;
        end else begin
            cnow = preload_req ? 32'hFFFF_FFFF : m_count;
            m_count <= cnow + 32'd1;
            if (en && req) begin
                m     = we & wstrb;
                isbad = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
                        (size == 2'd2 && (addr % 4) != 0);
                off   = addr[15:0];
                key   = int'((addr >> 2) & 32'h3FFF);
                if (isbad) begin
                    m_rdata <= 32'h0;
                    m_err   <= 1'b1;
                    if (!m_err) m_eaddr <= addr;
                end else if (addr[31:16] == MB[31:16]) begin
                    if (m == 4'd0) begin
                        case (off)
                            16'h0000: m_rdata <= cnow;
                            16'h0004: m_rdata <= {16'h0, m_led};
                            16'h0008: m_rdata <= m_scratch;
                            16'h000C: m_rdata <= {31'h0, m_err};
                            16'h0010: m_rdata <= m_eaddr;
                            default:  m_rdata <= 32'h0;
                        endcase
                    end else begin
                        if (off == 16'h0004) begin
                            tmp = merge({16'h0, m_led}, wdata, m);
                            m_led <= tmp[15:0];
                        end
                        if (off == 16'h0008) m_scratch <= merge(m_scratch, wdata, m);
                        if (off == 16'h000C && m[0] && wdata[0]) m_err <= 1'b0;
                    end
                end else begin
                    if (m == 4'd0) m_rdata <= m_ram[key];
                    else m_ram[key] <= merge(m_ram[key], wdata, m);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_rdata", rdata, m_rdata);
            check("cyc_led", {16'h0, led}, {16'h0, m_led});
            check("cyc_err", {31'h0, err}, {31'h0, m_err});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic acc(input logic [3:0] w, input logic [3:0] s, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; req = 1'b1; we = w; wstrb = s; size = sz; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; we = 4'h0; wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        acc(4'h0, 4'h0, 2'd2, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                      input logic [3:0] s);
        acc(w, s, 2'd2, a, d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c0;
        int unsigned off_tab [6];
        int unsigned u;
        int unsigned lo;
        off_tab = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20};
        resetn = 1'b0; en = 1'b0; req = 1'b0; we = 4'h0; wstrb = 4'h0;
        size = 2'd0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        wr(32'h100, 32'h1122_3344, 4'hF, 4'hF);
        rd(32'h100);
        check("word_rd", rdata, 32'h1122_3344);
        wr(32'h100, 32'h0000_AB00, 4'b0010, 4'hF);
        rd(32'h100);
        check("lane1_rd", rdata, 32'h1122_AB44);
        wr(32'h100, 32'h5500_0000, 4'hF, 4'b1000);
        rd(32'h100);
        check("strb3_rd", rdata, 32'h5522_AB44);
        wr(32'h100, 32'h1100_0000, 4'hF, 4'b1000);
        rd(32'h100);
        check("strb3_back", rdata, 32'h1122_AB44);

        acc(4'h0, 4'h0, 2'd1, 32'h101, 32'h0);
        check("half_bad_rdata", rdata, 32'h0);
        check("half_bad_err", {31'h0, err}, 32'h1);
        rd(MB | 32'h10);
        check("err_addr", rdata, 32'h101);
        acc(4'h0, 4'h0, 2'd2, 32'h203, 32'h0);
        rd(MB | 32'h10);
        check("err_addr_kept", rdata, 32'h101);
        wr(MB | 32'hC, 32'h1, 4'hF, 4'hF);
        check("err_clr", {31'h0, err}, 32'h0);
        acc(4'h0, 4'h0, 2'd1, 32'h203, 32'h0);
        acc(4'h1, 4'h1, 2'd3, MB | 32'hC, 32'h1);
        check("clr_vs_bad", {31'h0, err}, 32'h1);
        rd(MB | 32'h10);
        check("err_addr_new", rdata, 32'h203);
        wr(MB | 32'hC, 32'h1, 4'h1, 4'h1);
        check("err_clr2", {31'h0, err}, 32'h0);

        rd(MB);
        c0 = rdata;
        repeat (4) @(negedge clk);
        rd(MB);
        check("count_diff5", rdata - c0, 32'd5);
        wr(MB, 32'h0, 4'hF, 4'hF);
        rd(MB);
        force dut.r_count = 32'hFFFF_FFFF;
        preload_req = 1'b1;
        #1 release dut.r_count;
        rd(MB);
        preload_req = 1'b0;
        check("count_max", rdata, 32'hFFFF_FFFF);
        rd(MB);
        check("count_wrap", rdata, 32'h0);

        wr(MB | 32'h4, 32'hDEAD_BEEF, 4'hF, 4'hF);
        check("led_out", {16'h0, led}, 32'h0000_BEEF);
        rd(MB | 32'h4);
        check("led_rd", rdata, 32'h0000_BEEF);
        rd(MB | 32'h20);
        check("hole_rd", rdata, 32'h0);
        wr(MB | 32'h8, 32'hCAFE_F00D, 4'hF, 4'b0101);
        rd(MB | 32'h8);
        check("scratch_rd", rdata, 32'h00FE_000D);

        for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom, 4'hF, 4'hF);
        for (int n = 0; n < 400; n++) begin
            en    = ($urandom_range(0, 3) != 0);
            req   = ($urandom_range(0, 7) != 0);
            we    = 4'($urandom);
            wstrb = 4'($urandom);
            if ($urandom_range(0, 1) == 0) we = 4'h0;
            size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            lo    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 0;
            wdata = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                addr = MB | off_tab[$urandom_range(0, 5)] | lo;
            end else begin
                u = $urandom_range(0, 16'hFFFF);
                if (u == 32'h0000_BFAF) u = 0;
                addr = (u << 16) | ($urandom_range(0, 15) << 2) | lo;
            end
            @(negedge clk);
        end
        en = 1'b0; we = 4'h0; wstrb = 4'h0;
        @(negedge clk);

        wr(MB | 32'h4, 32'h0000_00FF, 4'hF, 4'hF);
        acc(4'h0, 4'h0, 2'd2, 32'h2, 32'h0);
        en = 1'b1; req = 1'b1; we = 4'h0; size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            addr = 32'(i * 4);
            @(negedge clk);
        end
        wr(32'h8, 32'h1234_5678, 4'hF, 4'hF);
        en = 1'b1; addr = 32'h8;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_rdata", rdata, 32'h0);
        check("rst_mid_led", {16'h0, led}, 32'h0);
        check("rst_mid_err", {31'h0, err}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rd(32'h100);
        check("ram_kept", rdata, 32'h1122_AB44);
        rd(MB | 32'h8);
        check("scratch_rst", rdata, 32'h0);
        rd(MB | 32'h10);
        check("err_addr_rst", rdata, 32'h0);
        @(negedge clk);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
